// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC select, FETCH/HALTED FSM and IF/DE latch.
// Optional `BTB_EN adds a 4-entry direct-mapped branch target buffer. It is indexed by PC[3:2]
// and tagged by PC[31:4]; with BTB_EN undefined there are no bt_* ports and de_pred is tied 0.
module fetch_unit #(
    parameter logic [31:0] PCINIT = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pcen,
    input  logic        deen,
    input  logic        deflush,
    input  logic [1:0]  PCSel,
    input  logic [31:0] brtarget,
    input  logic [31:0] jtarget,
    input  logic [31:0] jrtarget,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] iload,
`ifdef BTB_EN
    input  logic        bt_upd,
    input  logic [31:0] bt_pc,
    input  logic [31:0] bt_tgt,
    input  logic        bt_taken,
`endif
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] de_instr,
    output logic [31:0] de_npc,
    output logic        de_pred
);

    typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] de_instr_q, de_instr_d;
    logic [31:0] de_npc_q, de_npc_d;
    logic [31:0] seqpc;
    logic [31:0] nextpc;
    logic        btb_hit;
    logic [31:0] btb_target;

    // The hazard unit folds ihit into pcen/deen, so the fetch stage never looks at it.
    logic unused_ihit;
    assign unused_ihit = ihit;

`ifdef BTB_EN
    logic        valid_q [4];
    logic        valid_d [4];
    logic [27:0] tag_q   [4];
    logic [31:0] tgt_q   [4];
    logic        de_pred_q, de_pred_d;
    logic [1:0]  upd_idx;
    logic        unused_bt_pc;

    assign upd_idx      = bt_pc[3:2];
    assign unused_bt_pc = ^bt_pc[1:0];

    // Lookup reads only the registered arrays, so a same-cycle update is not yet visible.
    assign btb_hit    = valid_q[pc_q[3:2]] && (tag_q[pc_q[3:2]] == pc_q[31:4]);
    assign btb_target = tgt_q[pc_q[3:2]];

    // Valid-bit update: a taken branch allocates; a not-taken branch evicts only its own entry.
    always_comb begin
        for (int i = 0; i < 4; i++) valid_d[i] = valid_q[i];
        if (bt_upd) begin
            if (bt_taken)
                valid_d[upd_idx] = 1'b1;
            else if (tag_q[upd_idx] == bt_pc[31:4])
                valid_d[upd_idx] = 1'b0;
        end
    end

    // Valid bits are reset; tag and target payload are meaningless while invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) valid_q[i] <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) valid_q[i] <= valid_d[i];
        end
    end

    // Tag/target payload written on taken-branch allocation.
    always_ff @(posedge CLK) begin
        if (bt_upd && bt_taken) begin
            tag_q[upd_idx] <= bt_pc[31:4];
            tgt_q[upd_idx] <= bt_tgt;
        end
    end

    // Prediction flag is latched alongside the instruction it belongs to.
    always_comb begin
        de_pred_d = de_pred_q;
        if (deflush)
            de_pred_d = 1'b0;
        else if (deen && state_q == FETCH)
            de_pred_d = btb_hit;
    end

    // IF/DE prediction bit register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) de_pred_q <= 1'b0;
        else       de_pred_q <= de_pred_d;
    end

    assign de_pred = de_pred_q;
`else
    assign btb_hit    = 1'b0;
    assign btb_target = 32'h0;
    assign de_pred    = 1'b0;
`endif

    // Sequential PC wraps naturally modulo 2^32.
    assign seqpc = pc_q + 32'd4;

    // Next-PC select; a BTB hit only redirects the sequential path.
    always_comb begin
        nextpc = seqpc;
        unique case (PCSel)
            2'd0: nextpc = btb_hit ? btb_target : seqpc;
            2'd1: nextpc = brtarget;
            2'd2: nextpc = jtarget;
            2'd3: nextpc = jrtarget;
        endcase
    end

    // FSM, PC and IF/DE latch next-state; HALTED is left only through reset.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        de_instr_d = de_instr_q;
        de_npc_d   = de_npc_q;
        if (state_q == FETCH) begin
            if (halt && deen) state_d = HALTED;
            if (pcen)         pc_d    = nextpc;
        end
        if (deflush) begin
            de_instr_d = 32'h0;
            de_npc_d   = 32'h0;
        end else if (deen && state_q == FETCH) begin
            de_instr_d = iload;
            de_npc_d   = seqpc;
        end
    end

    // State, PC and IF/DE registers with asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            pc_q       <= PCINIT;
            de_instr_q <= 32'h0;
            de_npc_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            de_instr_q <= de_instr_d;
            de_npc_q   <= de_npc_d;
        end
    end

    assign imemaddr = pc_q;
    assign imemREN  = (state_q == FETCH);
    assign de_instr = de_instr_q;
    assign de_npc   = de_npc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for single-cycle behaviour, plus hand-written
// sequences for halt, asynchronous reset, PC wrap and (with BTB_EN) the branch target buffer.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        pcen, deen, deflush, halt, ihit;
    logic [1:0]  PCSel;
    logic [31:0] brtarget, jtarget, jrtarget, iload;
    logic        imemREN, de_pred;
    logic [31:0] imemaddr, de_instr, de_npc;
`ifdef BTB_EN
    logic        bt_upd, bt_taken;
    logic [31:0] bt_pc, bt_tgt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.PCINIT(32'h00000000)) dut (
        .CLK(CLK), .nRST(nRST), .pcen(pcen), .deen(deen), .deflush(deflush),
        .PCSel(PCSel), .brtarget(brtarget), .jtarget(jtarget), .jrtarget(jrtarget),
        .halt(halt), .ihit(ihit), .iload(iload),
`ifdef BTB_EN
        .bt_upd(bt_upd), .bt_pc(bt_pc), .bt_tgt(bt_tgt), .bt_taken(bt_taken),
`endif
        .imemREN(imemREN), .imemaddr(imemaddr), .de_instr(de_instr),
        .de_npc(de_npc), .de_pred(de_pred)
    );

    typedef struct {
        logic        pcen, deen, deflush;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic [31:0] iload;
        logic [31:0] exp_pc, exp_instr, exp_npc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        pcen = 0; deen = 0; deflush = 0; halt = 0; ihit = 1; PCSel = 0;
        brtarget = 0; jtarget = 0; jrtarget = 0; iload = 0;
`ifdef BTB_EN
        bt_upd = 0; bt_pc = 0; bt_tgt = 0; bt_taken = 0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // pcen deen flush sel tgt iload -> pc instr npc
        vecs[0]  = '{1,1,0,0,32'h0,  32'hA0, 32'h4,  32'hA0, 32'h4};
        vecs[1]  = '{1,1,0,0,32'h0,  32'hA1, 32'h8,  32'hA1, 32'h8};
        vecs[2]  = '{1,1,0,0,32'h0,  32'hA2, 32'hC,  32'hA2, 32'hC};
        vecs[3]  = '{1,1,1,1,32'h100,32'hA3, 32'h100,32'h0,  32'h0};
        vecs[4]  = '{1,1,0,2,32'h200,32'hA4, 32'h200,32'hA4, 32'h104};
        vecs[5]  = '{1,1,0,3,32'h300,32'hA5, 32'h300,32'hA5, 32'h204};
        vecs[6]  = '{0,0,0,0,32'h0,  32'hB0, 32'h300,32'hA5, 32'h204};
        vecs[7]  = '{0,0,0,1,32'h40, 32'hB1, 32'h300,32'hA5, 32'h204};
        vecs[8]  = '{0,0,0,3,32'h44, 32'hB2, 32'h300,32'hA5, 32'h204};
        vecs[9]  = '{0,1,1,0,32'h0,  32'hB3, 32'h300,32'h0,  32'h0};
        vecs[10] = '{1,1,0,1,32'h1C, 32'hC0, 32'h1C, 32'hC0, 32'h304};
        vecs[11] = '{1,1,0,0,32'h0,  32'hC1, 32'h20, 32'hC1, 32'h20};

        idle_inputs();
        nRST = 0;
        #12;
        chk("reset_pc",    imemaddr, 32'h0);
        chk("reset_ren",   {31'h0, imemREN}, 32'h1);
        chk("reset_instr", de_instr, 32'h0);
        chk("reset_npc",   de_npc,   32'h0);
        chk("reset_pred",  {31'h0, de_pred}, 32'h0);
        @(negedge CLK);
        nRST = 1;

        for (int i = 0; i < 12; i++) begin
            pcen = vecs[i].pcen; deen = vecs[i].deen; deflush = vecs[i].deflush;
            PCSel = vecs[i].sel; iload = vecs[i].iload;
            brtarget = vecs[i].tgt; jtarget = vecs[i].tgt; jrtarget = vecs[i].tgt;
            step();
            chk($sformatf("v%0d_pc", i),    imemaddr, vecs[i].exp_pc);
            chk($sformatf("v%0d_instr", i), de_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_npc", i),   de_npc,   vecs[i].exp_npc);
            chk($sformatf("v%0d_ren", i),   {31'h0, imemREN}, 32'h1);
        end

        // Halt at PC=0x20 (pcen low so the halting cycle itself does not advance PC).
        idle_inputs();
        halt = 1; deen = 1; iload = 32'hD0;
        step();
        chk("halt_ren",   {31'h0, imemREN}, 32'h0);
        chk("halt_pc",    imemaddr, 32'h20);
        chk("halt_instr", de_instr, 32'hD0);
        chk("halt_npc",   de_npc,   32'h24);
        idle_inputs();
        pcen = 1; deen = 1; PCSel = 1; brtarget = 32'h500;
        for (int i = 0; i < 3; i++) begin
            iload = 32'hE0 + i;
            step();
            chk("halted_pc",    imemaddr, 32'h20);
            chk("halted_ren",   {31'h0, imemREN}, 32'h0);
            chk("halted_instr", de_instr, 32'hD0);
        end
        deflush = 1;
        step();
        chk("halted_flush", de_instr, 32'h0);

        // Asynchronous reset pulse in the middle of a cycle.
        #2;
        nRST = 0;
        #1;
        chk("areset_pc",  imemaddr, 32'h0);
        chk("areset_ren", {31'h0, imemREN}, 32'h1);
        @(negedge CLK);
        nRST = 1;
        idle_inputs();
        pcen = 1; deen = 1; iload = 32'hF0;
        step();
        chk("after_reset_pc",    imemaddr, 32'h4);
        chk("after_reset_instr", de_instr, 32'hF0);

        // Wrap from the top of the address space.
        PCSel = 3; jrtarget = 32'hFFFFFFFC;
        step();
        chk("wrap_setup_pc", imemaddr, 32'hFFFFFFFC);
        PCSel = 0; iload = 32'hF1;
        step();
        chk("wrap_pc",  imemaddr, 32'h0);
        chk("wrap_npc", de_npc,   32'h0);

`ifdef BTB_EN
        idle_inputs();
        bt_upd = 1; bt_pc = 32'h10; bt_tgt = 32'h80; bt_taken = 1;
        step();
        idle_inputs();
        pcen = 1; deen = 1; PCSel = 3; jrtarget = 32'h10;
        step();
        chk("btb_visit_pc", imemaddr, 32'h10);
        PCSel = 0; iload = 32'h11;
        step();
        chk("btb_hit_pc",   imemaddr, 32'h80);
        chk("btb_hit_pred", {31'h0, de_pred}, 32'h1);
        chk("btb_hit_npc",  de_npc, 32'h14);
        idle_inputs();
        bt_upd = 1; bt_pc = 32'h10; bt_taken = 0;
        step();
        idle_inputs();
        pcen = 1; deen = 1; PCSel = 3; jrtarget = 32'h10;
        step();
        PCSel = 0;
        step();
        chk("btb_evict_pc",   imemaddr, 32'h14);
        chk("btb_evict_pred", {31'h0, de_pred}, 32'h0);
`else
        chk("no_btb_pred", {31'h0, de_pred}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
